kalman_gain_div: RTL
====================

# kalman_gain_div

Sequential fixed-point divider that computes the Kalman gain K = num/den for the Kalman filter stage. The filter sends the numerator (φ²·P + d_var) and the denominator (φ²·P + d_var + s_var) once per 1024-sample update. This block returns K as an unsigned pure fraction. It sits between the filter's numerator/denominator outputs and its K input, and uses a valid/ready handshake on both sides.

## Interface
- DATA_WIDTH, 32: width of the unsigned numerator and denominator, in the same fixed-point scale for both.
- Q_WIDTH, 24: number of fractional quotient bits. The result is unsigned Q0.Q_WIDTH.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- s_num  in  DATA_WIDTH  numerator.
- s_den  in  DATA_WIDTH  denominator.
- s_valid  in  1  request valid.
- s_ready  out  1  block can accept a request.
- m_quot  out  Q_WIDTH  gain K.
- m_sat  out  1  num ≥ den, so the quotient is clamped.
- m_dz  out  1  den == 0.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - s_ready = 1.
  - On s_valid & s_ready: latch den, load rem ← num, clear the quotient, load iteration counter ← Q_WIDTH (Q_WIDTH+1 when rounding is compiled in).
  - If den == 0: m_quot ← all ones, m_dz ← 1, m_sat ← 1, go to DONE.
  - Else if num ≥ den: m_quot ← all ones, m_sat ← 1, m_dz ← 0, go to DONE.
  - Else go to CALC.
- **CALC** (one restoring step per cycle, MSB first)
  - t = rem << 1, computed at DATA_WIDTH+1 bits.
  - If t ≥ den: rem ← t − den and shift 1 into the quotient.
  - Otherwise: rem ← t and shift 0 into the quotient.
  - Decrement the counter. When the step with counter == 1 completes, go to DONE.
- Width rule: num < den guarantees rem < den, so t < 2·den and DATA_WIDTH+1 bits never overflow.
- **DONE**
  - m_valid = 1. m_quot, m_sat and m_dz are held stable.
  - s_ready = 0.
  - On m_valid & m_ready, go to IDLE. m_valid drops on the next cycle.
- Only one request is in flight at a time, and no request is accepted in the cycle a result is consumed.
- s_num and s_den are sampled only on the accept edge. Changes to them afterwards are ignored.

## Timing
- Reset (rst = 0 at a clk edge):
  - state ← IDLE; m_valid, m_quot, m_sat, m_dz ← 0.
  - s_ready is 0 while rst is low and is 1 from the first cycle after release.
- Reset mid-CALC or mid-DONE aborts the operation. No m_valid is produced for the aborted request.
- Normal latency: accept edge at cycle 0, m_valid high from cycle Q_WIDTH, i.e. 24 cycles by default. Add 1 cycle when rounding is compiled in.
- Special cases (den == 0 or num ≥ den): m_valid high in cycle 1.
- Minimum request-to-request spacing is latency + 2 cycles, which is far below the 1024-cycle update period.
- m_valid never drops without m_ready. Outputs are registered with no combinational path from s_* to m_*.

## Configuration
- `KGAIN_DIV_ROUND_EN` defined:
  - One extra CALC step produces a guard bit.
  - On entry to DONE, if the guard bit is 1, m_quot ← m_quot + 1.
  - If m_quot is already all ones it is not incremented and m_sat ← 1.
  - Latency is Q_WIDTH+1 cycles.
- `KGAIN_DIV_ROUND_EN` undefined: the quotient is truncated and latency is Q_WIDTH cycles.

## Test plan
- **Basic divide:** num=1, den=2, Q_WIDTH=24 → m_quot=0x800000, m_sat=0, m_dz=0, m_valid high exactly 24 cycles after accept (25 with rounding).
- **Rounding:** num=2, den=3 → m_quot=0xAAAAAA when truncating, 0xAAAAAB with `KGAIN_DIV_ROUND_EN`. num=1, den=3 → 0x555555 in both builds.
- **Saturation and divide-by-zero:**
  - num=5, den=5 → m_quot=0xFFFFFF, m_sat=1, m_valid in cycle 1.
  - num=7, den=0 → m_quot=0xFFFFFF, m_dz=1, m_sat=1.
- **Backpressure:** hold m_ready=0 for 10 cycles after m_valid → m_quot and flags stay stable, s_ready=0 throughout. Raise m_ready → m_valid falls next cycle, s_ready rises.
- **Reset mid-operation:** pull rst low at cycle 10 of CALC → m_valid stays 0, s_ready is 1 after release. A fresh request num=3, den=4 returns 0xC00000.
- **Random sweep:** 1000 requests with random den > num > 0 and random m_ready stalls → m_quot equals floor(num·2^24/den), or the rounded value when rounding is compiled in.

Source files
------------

// File: rtl/kalman_gain_div.sv
// Restoring divider returning the Kalman gain K = num/den as an unsigned Q0.Q_WIDTH fraction.
// Optional round-to-nearest of the last quotient bit when KGAIN_DIV_ROUND_EN is defined.
module kalman_gain_div #(
    parameter int DATA_WIDTH = 32,
    parameter int Q_WIDTH    = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_num,
    input  logic [DATA_WIDTH-1:0] s_den,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [Q_WIDTH-1:0]    m_quot,
    output logic                  m_sat,
    output logic                  m_dz,
    output logic                  m_valid,
    input  logic                  m_ready
);

`ifdef KGAIN_DIV_ROUND_EN
    localparam int ITERS = Q_WIDTH + 1;
`else
    localparam int ITERS = Q_WIDTH;
`endif
    localparam int CNT_W = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_den;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [ITERS-1:0]      r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [Q_WIDTH-1:0]    r_quot;
    logic                  r_sat;
    logic                  r_dz;

    logic                  w_accept;
    logic                  w_special;
    logic                  w_last;
    logic [DATA_WIDTH:0]   w_t;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_sub;
    logic [ITERS-1:0]      w_acc_next;

    assign s_ready    = (r_state == IDLE) && rst;
    assign m_valid    = (r_state == DONE);
    assign m_quot     = r_quot;
    assign m_sat      = r_sat;
    assign m_dz       = r_dz;

    assign w_accept   = s_valid && s_ready;
    assign w_special  = (s_den == '0) || (s_num >= s_den);
    assign w_last     = (r_cnt == CNT_W'(1));

    // rem < den always holds in CALC, so the difference fits back into DATA_WIDTH bits
    assign w_t        = {r_rem, 1'b0};
    assign w_ge       = (w_t >= {1'b0, r_den});
    assign w_sub      = w_t[DATA_WIDTH-1:0] - r_den;
    assign w_acc_next = {r_acc[ITERS-2:0], w_ge};

`ifdef KGAIN_DIV_ROUND_EN
    logic [Q_WIDTH-1:0] w_trunc;
    assign w_trunc = w_acc_next[ITERS-1:1];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_den  <= '0;
            r_rem  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_sat  <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_den  <= s_den;
                        r_rem  <= s_num;
                        r_acc  <= '0;
                        r_cnt  <= CNT_W'(ITERS);
                        r_quot <= w_special ? '1 : '0;
                        r_sat  <= w_special;
                        r_dz   <= (s_den == '0);
                    end
                end
                CALC: begin
                    r_rem <= w_ge ? w_sub : w_t[DATA_WIDTH-1:0];
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
`ifdef KGAIN_DIV_ROUND_EN
                        // The guard bit rounds up unless that would wrap an all-ones quotient
                        if (w_acc_next[0]) begin
                            if (&w_trunc) begin
                                r_quot <= w_trunc;
                                r_sat  <= 1'b1;
                            end else begin
                                r_quot <= w_trunc + Q_WIDTH'(1);
                            end
                        end else begin
                            r_quot <= w_trunc;
                        end
`else
                        r_quot <= w_acc_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
